// File: rtl/norm1_sdiv_67s_43s_seq.sv
// Signed restoring radix-2 divider: quotient/remainder truncated toward zero, one quotient bit per cycle.
// Latency: out_valid DIN0_WIDTH cycles after accept; divide-by-zero is flagged on the accept edge itself.
// Backpressure: result held while out_ready=0; in_ready is low from accept until the result is taken.
module norm1_sdiv_67s_43s_seq #(
    parameter int DIN0_WIDTH = 67,
    parameter int DIN1_WIDTH = 43
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] dividend,
    input  logic [DIN1_WIDTH-1:0] divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIN0_WIDTH-1:0] quotient,
    output logic [DIN1_WIDTH-1:0] remainder,
    output logic                  div_by_zero
);
    localparam int CW = (DIN0_WIDTH > 1) ? $clog2(DIN0_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(DIN0_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state;
    logic [CW-1:0]         count;
    logic [DIN0_WIDTH-1:0] dvd_sr;
    logic [DIN1_WIDTH:0]   dsr_mag;
    logic [DIN1_WIDTH:0]   prem;
    logic                  sgn_dvd;
    logic                  sgn_dsr;

    logic [DIN0_WIDTH-1:0] dvd_abs;
    logic [DIN1_WIDTH:0]   dsr_ext;
    logic [DIN1_WIDTH:0]   dsr_abs;
    logic                  dsr_zero;
    logic [DIN1_WIDTH+1:0] trial;
    logic                  ge;
    logic [DIN1_WIDTH:0]   diff;
    logic [DIN1_WIDTH:0]   next_rem;
    logic [DIN0_WIDTH-1:0] next_q;
    logic [DIN0_WIDTH-1:0] quo_fix;
    logic [DIN1_WIDTH-1:0] rem_fix;

    always_comb begin
        // Magnitudes are unsigned, so the most-negative operand still fits.
        dvd_abs  = dividend[DIN0_WIDTH-1] ? -dividend : dividend;
        dsr_ext  = {divisor[DIN1_WIDTH-1], divisor};
        dsr_abs  = dsr_ext[DIN1_WIDTH] ? -dsr_ext : dsr_ext;
        dsr_zero = (divisor == '0);

        trial    = {prem, dvd_sr[DIN0_WIDTH-1]};
        ge       = (trial >= {1'b0, dsr_mag});
        diff     = trial[DIN1_WIDTH:0] - dsr_mag;
        next_rem = ge ? diff : trial[DIN1_WIDTH:0];
        // Quotient bits fill the dividend register from the bottom as its MSBs are consumed.
        next_q   = {dvd_sr[DIN0_WIDTH-2:0], ge};

        quo_fix  = (sgn_dvd ^ sgn_dsr) ? -next_q : next_q;
        rem_fix  = sgn_dvd ? -next_rem[DIN1_WIDTH-1:0] : next_rem[DIN1_WIDTH-1:0];
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            count       <= '0;
            dvd_sr      <= '0;
            dsr_mag     <= '0;
            prem        <= '0;
            sgn_dvd     <= 1'b0;
            sgn_dsr     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (dsr_zero) begin
                            quotient    <= '1;
                            remainder   <= '0;
                            div_by_zero <= 1'b1;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            dvd_sr  <= dvd_abs;
                            dsr_mag <= dsr_abs;
                            sgn_dvd <= dividend[DIN0_WIDTH-1];
                            sgn_dsr <= divisor[DIN1_WIDTH-1];
                            prem    <= '0;
                            count   <= CNT_INIT;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    prem   <= next_rem;
                    dvd_sr <= next_q;
                    count  <= count - CW'(1);
                    if (count == '0) begin
                        quotient    <= quo_fix;
                        remainder   <= rem_fix;
                        div_by_zero <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_norm1_sdiv_67s_43s_seq.sv
// Bench for the sequential signed divider: default 67/43 instance plus an 8/4 instance swept exhaustively.
module tb_norm1_sdiv_67s_43s_seq;
    localparam int W0 = 67;
    localparam int W1 = 43;

    logic ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    logic          ap_rst;
    logic          in_valid, in_ready, out_valid, out_ready, div_by_zero;
    logic [W0-1:0] dividend, quotient;
    logic [W1-1:0] divisor, remainder;

    logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_dz;
    logic [7:0]    s_dividend, s_quotient;
    logic [3:0]    s_divisor, s_remainder;

    int vectors = 0;
    int errors  = 0;

    norm1_sdiv_67s_43s_seq dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    norm1_sdiv_67s_43s_seq #(.DIN0_WIDTH(8), .DIN1_WIDTH(4)) dut_s (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .dividend(s_dividend), .divisor(s_divisor),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .quotient(s_quotient), .remainder(s_remainder), .div_by_zero(s_dz)
    );

    task automatic chk(input string tag, input logic [W0-1:0] got, input logic [W0-1:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain signed / and %, with the divide-by-zero convention layered on top.
    task automatic wide_op(input logic signed [W0-1:0] a, input logic signed [W1-1:0] b);
        logic [W0-1:0] eq;
        logic [W1-1:0] er;
        int lat;
        if (b == 0) begin
            eq = '1;
            er = '0;
        end else begin
            eq = a / b;
            er = a % b;
        end
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge ap_clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(negedge ap_clk);
            lat++;
        end
        chk("latency", W0'(lat), (b == 0) ? W0'(0) : W0'(W0));
        chk("quotient", quotient, eq);
        chk("remainder", W0'(remainder), W0'(er));
        chk("div_by_zero", W0'(div_by_zero), W0'(b == 0));
        out_ready = 1'b1;
        @(negedge ap_clk);
        out_ready = 1'b0;
        chk("idle_in_ready", W0'(in_ready), W0'(1));
        chk("idle_out_valid", W0'(out_valid), W0'(0));
    endtask

    task automatic small_op(input logic signed [7:0] a, input logic signed [3:0] b);
        logic [7:0] eq;
        logic [3:0] er;
        int lat;
        eq = a / b;
        er = a % b;
        s_in_valid = 1'b1;
        s_dividend = a;
        s_divisor  = b;
        @(negedge ap_clk);
        s_in_valid = 1'b0;
        lat = 0;
        while (!s_out_valid && lat < 50) begin
            @(negedge ap_clk);
            lat++;
        end
        chk("s_latency", W0'(lat), W0'(8));
        chk("s_quotient", W0'(s_quotient), W0'(eq));
        chk("s_remainder", W0'(s_remainder), W0'(er));
        chk("s_div_by_zero", W0'(s_dz), W0'(0));
        s_out_ready = 1'b1;
        @(negedge ap_clk);
        s_out_ready = 1'b0;
    endtask

    initial begin
        logic signed [W0-1:0] mn;
        logic signed [W0-1:0] ra;
        logic signed [W1-1:0] rb;
        logic [W0-1:0]        bq;
        logic [W1-1:0]        br;
        int                   lat;

        ap_rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_dividend = '0; s_divisor = '0;
        repeat (3) @(negedge ap_clk);
        ap_rst = 1'b0;
        @(negedge ap_clk);
        chk("rst_in_ready", W0'(in_ready), W0'(1));
        chk("rst_out_valid", W0'(out_valid), W0'(0));
        chk("rst_quotient", quotient, W0'(0));
        chk("rst_remainder", W0'(remainder), W0'(0));
        chk("rst_div_by_zero", W0'(div_by_zero), W0'(0));

        wide_op(1000, 7);
        wide_op(-1000, 7);
        wide_op(1000, -7);
        wide_op(-1000, -7);
        wide_op(5, 0);
        mn = {1'b1, {(W0-1){1'b0}}};
        wide_op(mn, -1);
        wide_op(mn, 7);
        wide_op(mn, {1'b1, {(W1-1){1'b0}}});
        wide_op(mn + 1, 1);

        for (int i = 0; i < 40; i++) begin
            ra = W0'({$urandom(), $urandom(), $urandom()});
            case ($urandom_range(0, 3))
                0: rb = W1'({$urandom(), $urandom()});
                1: begin
                    rb = W1'($urandom_range(1, 5000));
                    if ($urandom_range(0, 1) == 1) rb = -rb;
                end
                2: rb = '0;
                default: begin
                    ra = W0'(signed'($urandom_range(0, 200000)) - 100000);
                    rb = W1'($urandom_range(1, 300));
                end
            endcase
            wide_op(ra, rb);
        end

        // Backpressure: result must hold and stray in_valid pulses must not be taken.
        ra = 12345; rb = -10;
        bq = ra / rb; br = ra % rb;
        in_valid = 1'b1; dividend = ra; divisor = rb;
        @(negedge ap_clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(negedge ap_clk);
            lat++;
        end
        chk("bp_latency", W0'(lat), W0'(W0));
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'(($urandom_range(0, 1)));
            dividend = W0'($urandom());
            divisor  = W1'($urandom_range(1, 9));
            @(negedge ap_clk);
            chk("bp_quotient", quotient, bq);
            chk("bp_remainder", W0'(remainder), W0'(br));
            chk("bp_out_valid", W0'(out_valid), W0'(1));
            chk("bp_in_ready", W0'(in_ready), W0'(0));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge ap_clk);
        out_ready = 1'b0;
        chk("bp_release_in_ready", W0'(in_ready), W0'(1));
        chk("bp_release_out_valid", W0'(out_valid), W0'(0));
        wide_op(77, 5);

        // Reset while calculating drops the operation.
        in_valid = 1'b1; dividend = 999999; divisor = 13;
        @(negedge ap_clk);
        in_valid = 1'b0;
        repeat (29) @(negedge ap_clk);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        chk("midrst_out_valid", W0'(out_valid), W0'(0));
        chk("midrst_in_ready", W0'(in_ready), W0'(1));
        wide_op(100, 3);

        for (int i = -128; i < 128; i++) begin
            for (int j = -8; j < 8; j++) begin
                if (j != 0) small_op(8'(i), 4'(j));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
